// File: rtl/r2r_dac_sequencer_if.sv
// ---------------------------------------------------------------------------
// r2r_dac_sequencer_if
//
// Bundles the host command port and the DAC-side status outputs of the
// R2R DAC waveform sequencer.
//
// Handshake: cmd_valid is a one-cycle strobe with no ready signal. The
// sequencer consumes exactly one command (cmd, data) on every clk edge where
// cmd_valid is high. It never back-pressures. A command that cannot be
// honoured is dropped and reported by a one-cycle cmd_err pulse.
//
// Signals:
//   cmd_valid  host -> seq   command strobe
//   cmd[2:0]   host -> seq   opcode
//   data[7:0]  host -> seq   command operand
//   dac_out    seq  -> host  registered 8-bit DAC code
//   running    seq  -> host  high in any RUN state
//   tick       seq  -> host  pulse while a rate-driven dac_out value is new
//   wrap       seq  -> host  pulse with tick when the sequence restarts
//   cmd_err    seq  -> host  pulse in the cycle after a rejected command
//   state_dbg  seq  -> host  current FSM state, for observation only
// ---------------------------------------------------------------------------
interface r2r_dac_sequencer_if;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [7:0] data;
    logic [7:0] dac_out;
    logic       running;
    logic       tick;
    logic       wrap;
    logic       cmd_err;
    logic [1:0] state_dbg;

    modport master (
        output cmd_valid, cmd, data,
        input  dac_out, running, tick, wrap, cmd_err, state_dbg
    );

    modport slave (
        input  cmd_valid, cmd, data,
        output dac_out, running, tick, wrap, cmd_err, state_dbg
    );
endinterface

// File: rtl/r2r_dac_sequencer.sv
// ---------------------------------------------------------------------------
// r2r_dac_sequencer
//
// Command-driven waveform sequencer for an 8-bit R2R DAC. It holds a
// 16-entry sample table and steps dac_out at a programmable rate in ramp,
// triangle or table-playback mode. The sample period is
// (divider+1) << PRESCALE_SHIFT clocks.
//
// Ports:
//   clk    system clock
//   n_rst  asynchronous reset, active high (despite the name)
//   bus    r2r_dac_sequencer_if.slave: command input, DAC code and status
// ---------------------------------------------------------------------------
module r2r_dac_sequencer #(
    parameter int unsigned PRESCALE_SHIFT = 8
) (
    input logic                clk,
    input logic                n_rst,
    r2r_dac_sequencer_if.slave bus
);
    localparam int unsigned CW = 8 + PRESCALE_SHIFT;
    // Low PRESCALE_SHIFT bits set: ((d+1) << S) - 1 == (d << S) | LOW_ONES.
    localparam logic [CW-1:0] LOW_ONES = CW'((64'd1 << PRESCALE_SHIFT) - 64'd1);

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_SET_DIV = 3'd1;
    localparam logic [2:0] OP_SET_LEN = 3'd2;
    localparam logic [2:0] OP_WRITE   = 3'd3;
    localparam logic [2:0] OP_START   = 3'd4;
    localparam logic [2:0] OP_STOP    = 3'd5;
    localparam logic [2:0] OP_SET_OUT = 3'd6;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN_RAMP  = 2'd1,
        RUN_TRI   = 2'd2,
        RUN_TABLE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    divider_q;
    logic [3:0]    len_m1_q;
    logic [3:0]    wptr_q;
    logic [3:0]    idx_q;
    logic          dir_down_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    table_q [16];
    logic [7:0]    dac_q;
    logic          tick_q, wrap_q, err_q;

    logic          is_run, at_tc, advance, reject;
    logic          do_div, do_len, do_write, do_out, do_start, do_stop;
    logic [CW-1:0] term_cnt;
    logic [3:0]    idx_next;
    logic [7:0]    adv_dac;
    logic [3:0]    adv_idx;
    logic          adv_dir, adv_wrap;

    assign is_run   = (state_q != IDLE);
    assign term_cnt = (CW'(divider_q) << PRESCALE_SHIFT) | LOW_ONES;
    assign at_tc    = is_run && (cnt_q == term_cnt);
    // STOP and SET_DIV both take priority over a coincident terminal count.
    assign advance  = at_tc && !do_div && !do_stop;
    assign idx_next = (idx_q == len_m1_q) ? 4'd0 : idx_q + 4'd1;

    // Command decode and next-state.
    always_comb begin
        state_d  = state_q;
        reject   = 1'b0;
        do_div   = 1'b0;
        do_len   = 1'b0;
        do_write = 1'b0;
        do_out   = 1'b0;
        do_start = 1'b0;
        do_stop  = 1'b0;
        if (bus.cmd_valid) begin
            case (bus.cmd)
                OP_NOP:     ;
                OP_SET_DIV: do_div = 1'b1;
                OP_SET_LEN: if (is_run) reject = 1'b1; else do_len   = 1'b1;
                OP_WRITE:   if (is_run) reject = 1'b1; else do_write = 1'b1;
                OP_SET_OUT: if (is_run) reject = 1'b1; else do_out   = 1'b1;
                OP_START: begin
                    if (is_run || bus.data[1:0] == 2'd3) begin
                        reject = 1'b1;
                    end else begin
                        do_start = 1'b1;
                        case (bus.data[1:0])
                            2'd0:    state_d = RUN_RAMP;
                            2'd1:    state_d = RUN_TRI;
                            default: state_d = RUN_TABLE;
                        endcase
                    end
                end
                OP_STOP: begin
                    do_stop = 1'b1;
                    state_d = IDLE;
                end
                default: reject = 1'b1;
            endcase
        end
    end

    // Value produced by one advance of the active mode.
    always_comb begin
        adv_dac  = dac_q;
        adv_idx  = idx_q;
        adv_dir  = dir_down_q;
        adv_wrap = 1'b0;
        case (state_q)
            RUN_RAMP: begin
                adv_dac  = dac_q + 8'd1;
                adv_wrap = (dac_q == 8'hFF);
            end
            RUN_TRI: begin
                if (!dir_down_q) begin
                    adv_dac = dac_q + 8'd1;
                    if (dac_q == 8'hFE) adv_dir = 1'b1;
                end else begin
                    adv_dac = dac_q - 8'd1;
                    if (dac_q == 8'h01) begin
                        adv_dir  = 1'b0;
                        adv_wrap = 1'b1;
                    end
                end
            end
            RUN_TABLE: begin
                adv_idx  = idx_next;
                adv_dac  = table_q[idx_next];
                adv_wrap = (idx_next == 4'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            divider_q  <= 8'd0;
            len_m1_q   <= 4'hF;
            wptr_q     <= 4'd0;
            idx_q      <= 4'd0;
            dir_down_q <= 1'b0;
            cnt_q      <= '0;
            dac_q      <= 8'd0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < 16; i++) table_q[i] <= 8'd0;
        end else begin
            tick_q <= advance;
            wrap_q <= advance && adv_wrap;
            err_q  <= reject;

            if (do_div) divider_q <= bus.data;

            if (do_div || do_stop || do_start || at_tc) cnt_q <= '0;
            else if (is_run)                            cnt_q <= cnt_q + CW'(1);

            if (do_len) begin
                len_m1_q <= bus.data[3:0];
                wptr_q   <= 4'd0;
            end
            if (do_write) begin
                table_q[wptr_q] <= bus.data;
                wptr_q          <= wptr_q + 4'd1;
            end
            if (do_out) dac_q <= bus.data;
            if (do_start) begin
                idx_q      <= 4'd0;
                dir_down_q <= 1'b0;
                dac_q      <= (bus.data[1:0] == 2'd2) ? table_q[0] : 8'd0;
            end
            // Only reachable in RUN states, so never collides with the
            // IDLE-only writes above.
            if (advance) begin
                dac_q      <= adv_dac;
                idx_q      <= adv_idx;
                dir_down_q <= adv_dir;
            end
        end
    end

    assign bus.dac_out   = dac_q;
    assign bus.running   = is_run;
    assign bus.tick      = tick_q;
    assign bus.wrap      = wrap_q;
    assign bus.cmd_err   = err_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_r2r_dac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_r2r_dac_sequencer
//
// Bench for r2r_dac_sequencer (PRESCALE_SHIFT = 0). A reference model
// tracks commands at edge level and, for every edge where the sequencer
// should produce a tick or cmd_err, pushes the expected cycle, tick, wrap,
// cmd_err and dac_out into exp_q. The monitor pops on every DUT event.
// Waveform values are computed from the advance index k with plain
// arithmetic (k mod 256, triangle folding of k mod 510, table[k mod len]).
// ---------------------------------------------------------------------------
module tb_r2r_dac_sequencer;
    localparam int SHIFT = 0;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic n_rst = 1'b1;
    always #5 clk = ~clk;

    r2r_dac_sequencer_if bus();

    r2r_dac_sequencer #(.PRESCALE_SHIFT(SHIFT)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Record layout: [42:11] cycle, [10] tick, [9] wrap, [8] cmd_err, [7:0] dac
    logic [42:0] exp_q[$];
    int          cyc         = 0;
    int          m_state     = 0;   // 0 idle, 1 ramp, 2 triangle, 3 table
    int          m_div       = 0;
    int          m_len       = 15;
    int          m_wptr      = 0;
    int          m_k         = 0;
    int          m_next_edge = 0;
    int          m_period    = 1;
    logic [7:0]  m_dac       = 8'd0;
    logic [7:0]  m_tbl [16];

    function automatic logic [8:0] ref_point(input int k);
        int r;
        logic [7:0] v;
        logic w;
        case (m_state)
            1: begin r = k % 256; v = 8'(r); w = (r == 0); end
            2: begin
                r = k % 510;
                v = (r <= 255) ? 8'(r) : 8'(510 - r);
                w = (r == 0);
            end
            default: begin r = k % (m_len + 1); v = m_tbl[r]; w = (r == 0); end
        endcase
        return {w, v};
    endfunction

    initial begin
        logic       t, w, e, stop_now, div_now;
        logic [8:0] pt;
        for (int i = 0; i < 16; i++) m_tbl[i] = 8'd0;
        forever begin
            @(posedge clk or posedge n_rst);
            if (n_rst) begin
                m_state = 0; m_div = 0; m_len = 15; m_wptr = 0; m_k = 0;
                m_next_edge = 0; m_period = 1; m_dac = 8'd0;
                for (int i = 0; i < 16; i++) m_tbl[i] = 8'd0;
                exp_q.delete();
            end else begin
                cyc++;
                t = 1'b0; w = 1'b0; e = 1'b0;
                stop_now = bus.cmd_valid && bus.cmd == 3'd5;
                div_now  = bus.cmd_valid && bus.cmd == 3'd1;
                if (m_state != 0 && cyc == m_next_edge && !stop_now && !div_now) begin
                    m_k++;
                    pt = ref_point(m_k);
                    m_dac = pt[7:0];
                    t = 1'b1;
                    w = pt[8];
                    m_next_edge = cyc + m_period;
                end
                if (bus.cmd_valid) begin
                    case (bus.cmd)
                        3'd1: begin
                            m_div = int'(bus.data);
                            m_period = (m_div + 1) << SHIFT;
                            m_next_edge = cyc + m_period;
                        end
                        3'd2: if (m_state != 0) e = 1'b1;
                              else begin m_len = int'(bus.data[3:0]); m_wptr = 0; end
                        3'd3: if (m_state != 0) e = 1'b1;
                              else begin m_tbl[m_wptr] = bus.data; m_wptr = (m_wptr + 1) % 16; end
                        3'd4: if (m_state != 0 || bus.data[1:0] == 2'd3) e = 1'b1;
                              else begin
                                  m_state = int'(bus.data[1:0]) + 1;
                                  m_k = 0;
                                  m_period = (m_div + 1) << SHIFT;
                                  m_next_edge = cyc + m_period;
                                  m_dac = (bus.data[1:0] == 2'd2) ? m_tbl[0] : 8'd0;
                              end
                        3'd5: m_state = 0;
                        3'd6: if (m_state != 0) e = 1'b1; else m_dac = bus.data;
                        3'd7: e = 1'b1;
                        default: ;
                    endcase
                end
                if (t || e) exp_q.push_back({32'(cyc), t, w, e, m_dac});
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [42:0] head;
        logic [10:0] act;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                while (exp_q.size() > 0) begin
                    head = exp_q[0];
                    if (int'(head[42:11]) >= cyc) break;
                    checks++; errors++;
                    $display("FAIL missed_event: expected tick=%0b wrap=%0b err=%0b dac=%02h at cycle %0d but the DUT did not produce it",
                             head[10], head[9], head[8], head[7:0], int'(head[42:11]));
                    void'(exp_q.pop_front());
                end
                if (bus.tick || bus.cmd_err || bus.wrap) begin
                    act = {bus.tick, bus.wrap, bus.cmd_err, bus.dac_out};
                    checks++;
                    if (exp_q.size() == 0 || int'(exp_q[0][42:11]) != cyc) begin
                        errors++;
                        $display("FAIL unexpected_event: cycle %0d got tick=%0b wrap=%0b err=%0b dac=%02h, none expected",
                                 cyc, act[10], act[9], act[8], act[7:0]);
                    end else begin
                        head = exp_q.pop_front();
                        if (act !== head[10:0]) begin
                            errors++;
                            $display("FAIL event: cycle %0d got tick=%0b wrap=%0b err=%0b dac=%02h, expected tick=%0b wrap=%0b err=%0b dac=%02h",
                                     cyc, act[10], act[9], act[8], act[7:0],
                                     head[10], head[9], head[8], head[7:0]);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called 1 ns after a posedge; the command is accepted at the next edge.
    task automatic issue(input logic [2:0] c, input logic [7:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.data      = d;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 3'd0;
        bus.data      = 8'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue a command so that it lands on a terminal-count edge.
    task automatic wait_tc_issue(input logic [2:0] c, input logic [7:0] d);
        int n = 0;
        while (!(m_state != 0 && m_next_edge == cyc + 1) && n < 2000) begin
            idle(1);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL tc_wait: no terminal count within %0d cycles", n);
        end
        issue(c, d);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd       = 3'd0;
        bus.data      = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b0;

        check("rst_dac",     32'(bus.dac_out),   32'h0);
        check("rst_running", 32'(bus.running),   32'h0);
        check("rst_tick",    32'(bus.tick),      32'h0);
        check("rst_wrap",    32'(bus.wrap),      32'h0);
        check("rst_cmd_err", 32'(bus.cmd_err),   32'h0);
        check("rst_state",   32'(bus.state_dbg), 32'h0);

        // SET_OUT in IDLE, then rejected opcodes.
        issue(3'd6, 8'hA5);
        check("set_out", 32'(bus.dac_out), 32'hA5);
        issue(3'd7, 8'($urandom_range(0, 255)));
        issue(3'd4, {6'($urandom_range(0, 63)), 2'b11});
        check("start3_idle", 32'(bus.running), 32'h0);

        // Ramp, divider 2, through the 0xFF->0x00 wrap, STOP on a TC edge.
        issue(3'd1, 8'd2);
        issue(3'd4, 8'd0);
        check("ramp_running", 32'(bus.running), 32'h1);
        check("ramp_start",   32'(bus.dac_out), 32'h0);
        idle(3 * 258);
        wait_tc_issue(3'd5, 8'd0);
        check("stop_running", 32'(bus.running), 32'h0);
        idle(4);
        check("stop_hold", 32'(bus.dac_out), 32'(m_dac));

        // SET_DIV mid-run and SET_DIV colliding with terminal count.
        issue(3'd1, 8'd0);
        issue(3'd4, 8'd0);
        idle($urandom_range(5, 40));
        issue(3'd1, 8'd4);
        idle(23);
        wait_tc_issue(3'd1, 8'd1);
        idle(20);
        issue(3'd5, 8'd0);

        // Table playback, length 3.
        issue(3'd2, 8'd2);
        issue(3'd3, 8'h10);
        issue(3'd3, 8'h80);
        issue(3'd3, 8'hF0);
        issue(3'd1, 8'd0);
        issue(3'd4, 8'd2);
        check("table_start", 32'(bus.dac_out), 32'h10);
        idle(10);
        issue(3'd5, 8'd0);

        // Table length 4; rejected WRITE must not move table or wptr.
        issue(3'd2, 8'hF3);
        issue(3'd3, 8'h11);
        issue(3'd3, 8'h22);
        issue(3'd3, 8'h33);
        issue(3'd4, 8'd2);
        idle(6);
        issue(3'd3, 8'h55);
        idle(5);
        issue(3'd5, 8'd0);
        issue(3'd3, 8'h66);
        issue(3'd4, 8'd2);
        idle(12);
        issue(3'd5, 8'd0);

        // Triangle, divider 0, two full periods.
        issue(3'd1, 8'd0);
        issue(3'd4, 8'd1);
        idle(1100);
        issue(3'd5, 8'd0);

        // Asynchronous reset between edges while ramping at 0x37.
        issue(3'd4, 8'd0);
        idle(8'h37);
        check("pre_reset_dac", 32'(bus.dac_out), 32'h37);
        #1 n_rst = 1'b1;
        #1;
        check("async_rst_dac",     32'(bus.dac_out), 32'h0);
        check("async_rst_running", 32'(bus.running), 32'h0);
        #1 n_rst = 1'b0;
        @(posedge clk);
        #1;
        issue(3'd5, 8'd0);
        check("stop_after_rst_err", 32'(bus.cmd_err), 32'h0);

        // Random command traffic.
        for (int i = 0; i < 300; i++) begin
            logic [2:0] op;
            logic [7:0] d;
            op = 3'($urandom_range(0, 7));
            d  = (op == 3'd1) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
            issue(op, d);
            idle($urandom_range(0, 8));
        end
        issue(3'd5, 8'd0);
        idle(5);
        check("final_dac",   32'(bus.dac_out), 32'(m_dac));
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
